// File: rtl/sync_updown_counter_if.sv
// Control and count bundle for the synchronous modulo-N up/down counter.
// Latency: none of its own; it only groups signals.
// Backpressure: none; the counter accepts a control word every clock.
interface sync_updown_counter_if #(
  parameter int WIDTH = 6
);
  // Controls from the user of the counter
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  // Count state and cascade outputs from the counter
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qnot;
  logic             tc;
  logic             wrap;

  // The block driving controls and consuming the count
  modport master (
    output en, up, load, din,
    input  q, qnot, tc, wrap
  );

  // The counter itself
  modport slave (
    input  en, up, load, din,
    output q, qnot, tc, wrap
  );
endinterface

// File: rtl/sync_updown_counter.sv
// Synchronous modulo-MODULUS up/down counter with saturating parallel load and cascade tc.
// Latency: q and wrap update one clk after the controls are sampled; tc and qnot are combinational.
// Backpressure: none; en/load are honoured on every edge, with clear > load > en > hold.
module sync_updown_counter #(
  parameter int WIDTH   = 6,
  parameter int MODULUS = 64
) (
  input logic                 clk,
  input logic                 clear,
  sync_updown_counter_if.slave bus
);

  // Reject moduli that cannot be represented or that would allow back-to-back wraps
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("sync_updown_counter: MODULUS must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_r;
  logic             at_end;
  logic             tc;

  // Terminal condition for the current direction, then gate it into the cascade carry/borrow
  always_comb begin
    at_end = bus.up ? (q_r == MAXV) : (q_r == '0);
    tc     = bus.en & ~bus.load & at_end;
  end

  // Next count: saturating load wins, otherwise count modulo MODULUS in the chosen direction
  always_comb begin
    q_nxt = q_r;
    if (bus.load) begin
      q_nxt = (bus.din > MAXV) ? MAXV : bus.din;
    end else if (bus.en) begin
      if (bus.up) begin
        q_nxt = at_end ? '0 : q_r + ONE;
      end else begin
        q_nxt = at_end ? MAXV : q_r - ONE;
      end
    end
  end

  // Count and wrap registers; clear acts immediately and masks every edge while high
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= tc;
    end
  end

  assign bus.q    = q_r;
  assign bus.qnot = ~q_r;
  assign bus.tc   = tc;
  assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_sync_updown_counter.sv
module tb_sync_updown_counter;

  logic clk = 1'b0;
  logic clear;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sync_updown_counter_if #(.WIDTH(6)) a_if ();
  sync_updown_counter_if #(.WIDTH(4)) b_if ();
  sync_updown_counter_if #(.WIDTH(6)) lo_if ();
  sync_updown_counter_if #(.WIDTH(6)) hi_if ();

  assign hi_if.en = lo_if.tc;

  sync_updown_counter #(.WIDTH(6), .MODULUS(64)) u_a  (.clk(clk), .clear(clear), .bus(a_if));
  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u_b  (.clk(clk), .clear(clear), .bus(b_if));
  sync_updown_counter #(.WIDTH(6), .MODULUS(64)) u_lo (.clk(clk), .clear(clear), .bus(lo_if));
  sync_updown_counter #(.WIDTH(6), .MODULUS(64)) u_hi (.clk(clk), .clear(clear), .bus(hi_if));

  // Reference state: plain integers counted modulo the stage's range
  int ea, eb, elo, ehi;
  bit wa, wb, wlo, whi;

  function automatic int nq(int q, bit en, bit up, bit ld, int din, int m);
    if (ld) return (din > m - 1) ? m - 1 : din;
    if (!en) return q;
    if (up) return (q + 1) % m;
    return (q + m - 1) % m;
  endfunction

  function automatic bit term(int q, bit en, bit up, bit ld, int m);
    return en && !ld && (up ? (q == m - 1) : (q == 0));
  endfunction

  task automatic reset_models();
    ea = 0; eb = 0; elo = 0; ehi = 0;
    wa = 0; wb = 0; wlo = 0; whi = 0;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit tlo;
    tlo = term(elo, lo_if.en, lo_if.up, lo_if.load, 64);
    check("a_q", a_if.q, ea);
    check("a_qnot", a_if.qnot, 63 - ea);
    check("a_tc", a_if.tc, term(ea, a_if.en, a_if.up, a_if.load, 64));
    check("a_wrap", a_if.wrap, wa);
    check("b_q", b_if.q, eb);
    check("b_qnot", b_if.qnot, 15 - eb);
    check("b_tc", b_if.tc, term(eb, b_if.en, b_if.up, b_if.load, 10));
    check("b_wrap", b_if.wrap, wb);
    check("b_range", b_if.q < 4'd10, 1);
    check("lo_q", lo_if.q, elo);
    check("lo_qnot", lo_if.qnot, 63 - elo);
    check("lo_tc", lo_if.tc, tlo);
    check("lo_wrap", lo_if.wrap, wlo);
    check("hi_q", hi_if.q, ehi);
    check("hi_qnot", hi_if.qnot, 63 - ehi);
    check("hi_tc", hi_if.tc, term(ehi, tlo, hi_if.up, hi_if.load, 64));
    check("hi_wrap", hi_if.wrap, whi);
  endtask

  // One clock: advance the reference on the edge, compare on the following falling edge
  task automatic tick();
    bit tlo;
    @(posedge clk);
    if (clear) begin
      reset_models();
    end else begin
      tlo = term(elo, lo_if.en, lo_if.up, lo_if.load, 64);
      wa  = term(ea, a_if.en, a_if.up, a_if.load, 64);
      ea  = nq(ea, a_if.en, a_if.up, a_if.load, int'(a_if.din), 64);
      wb  = term(eb, b_if.en, b_if.up, b_if.load, 10);
      eb  = nq(eb, b_if.en, b_if.up, b_if.load, int'(b_if.din), 10);
      whi = term(ehi, tlo, hi_if.up, hi_if.load, 64);
      ehi = nq(ehi, tlo, hi_if.up, hi_if.load, int'(hi_if.din), 64);
      wlo = tlo;
      elo = nq(elo, lo_if.en, lo_if.up, lo_if.load, int'(lo_if.din), 64);
    end
    @(negedge clk);
    check_all();
  endtask

  // Raise clear between edges and confirm its effect is immediate
  task automatic do_clear();
    clear = 1'b1;
    #1;
    reset_models();
    check_all();
    check("clr_q", a_if.q, 0);
    check("clr_qnot", a_if.qnot, 63);
  endtask

  task automatic drive_a(bit en, bit up, bit ld, logic [5:0] din);
    a_if.en = en; a_if.up = up; a_if.load = ld; a_if.din = din;
  endtask

  task automatic drive_b(bit en, bit up, bit ld, logic [3:0] din);
    b_if.en = en; b_if.up = up; b_if.load = ld; b_if.din = din;
  endtask

  initial begin
    clear = 1'b1;
    drive_a(0, 0, 0, '0);
    drive_b(0, 0, 0, '0);
    lo_if.en = 0; lo_if.up = 0; lo_if.load = 0; lo_if.din = '0;
    hi_if.up = 0; hi_if.load = 0; hi_if.din = '0;
    reset_models();
    #1;
    check_all();
    check("rst_wrap", a_if.wrap, 0);
    #6;
    clear = 1'b0;

    // Count up through a full wrap
    drive_a(1, 1, 0, '0);
    repeat (70) tick();
    check("up70", a_if.q, 6);

    // Count down from reset: first edge lands on 63
    @(negedge clk);
    do_clear();
    drive_a(1, 0, 0, '0);
    tick();
    clear = 1'b0;
    tick();
    check("down_first", a_if.q, 63);
    check("down_wrap", a_if.wrap, 1);
    repeat (64) tick();

    // Saturating loads on the modulo-10 stage
    drive_a(0, 0, 0, '0);
    drive_b(0, 0, 1, 4'd7);
    tick();
    check("ld7", b_if.q, 7);
    drive_b(0, 0, 1, 4'd12);
    tick();
    check("ld12", b_if.q, 9);
    drive_b(1, 1, 1, 4'd3);
    tick();
    check("ld_over_en", b_if.q, 3);
    drive_b(0, 0, 1, 4'd15);
    tick();
    check("ld15", b_if.q, 9);

    // Randomised controls on every stage
    for (int i = 0; i < 300; i++) begin
      drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 7) == 0, 6'($urandom_range(0, 63)));
      drive_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)));
      lo_if.en   = 1'($urandom_range(0, 1));
      lo_if.up   = 1'($urandom_range(0, 1));
      lo_if.load = $urandom_range(0, 15) == 0;
      lo_if.din  = 6'($urandom_range(0, 63));
      hi_if.up   = 1'($urandom_range(0, 1));
      hi_if.load = $urandom_range(0, 31) == 0;
      hi_if.din  = 6'($urandom_range(0, 63));
      tick();
    end

    // Enable gating and direction flip
    lo_if.en = 0; lo_if.load = 0; hi_if.load = 0;
    drive_b(0, 0, 0, '0);
    do_clear();
    drive_a(1, 1, 0, '0);
    clear = 1'b0;
    repeat (5) tick();
    check("gate_at5", a_if.q, 5);
    drive_a(0, 1, 0, '0);
    repeat (3) tick();
    check("gate_hold", a_if.q, 5);
    drive_a(1, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("flip_nowrap", a_if.wrap, 0);
    end
    check("flip_at0", a_if.q, 0);

    // Clear during a wrap pulse, and held across a load edge
    drive_a(0, 0, 1, 6'd63);
    tick();
    drive_a(1, 1, 0, '0);
    tick();
    check("wrap_pulse", a_if.wrap, 1);
    do_clear();
    check("clr_wrap", a_if.wrap, 0);
    drive_a(1, 1, 1, 6'd20);
    tick();
    check("clr_vs_load", a_if.q, 0);
    clear = 1'b0;

    // Async clear mid-count at 37, then resume from 0
    drive_a(1, 1, 0, '0);
    repeat (37) tick();
    check("at37", a_if.q, 37);
    #2;
    do_clear();
    tick();
    clear = 1'b0;
    repeat (3) tick();
    check("resume", a_if.q, 3);

    // Two-stage cascade across its full range
    drive_a(0, 0, 0, '0);
    do_clear();
    lo_if.en = 1; lo_if.up = 1; lo_if.load = 0; lo_if.din = '0;
    hi_if.up = 1; hi_if.load = 0; hi_if.din = '0;
    clear = 1'b0;
    repeat (64) tick();
    check("casc64_lo", lo_if.q, 0);
    check("casc64_hi", hi_if.q, 1);
    repeat (4096 - 64) tick();
    check("casc4096_lo", lo_if.q, 0);
    check("casc4096_hi", hi_if.q, 0);
    check("casc4096_wrap", hi_if.wrap, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
